// File: rtl/opb_reg_master.sv
// Single-outstanding OPB register initiator.
// Command channel in, one strobe per access, registered response out.
module opb_reg_master #(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             OPB_CLK,
    input  logic             OPB_RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WR,
    input  logic [31:0]      CMD_ADDR,
    input  logic [31:0]      CMD_WDATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_WR,
    output logic [31:0]      RSP_RDATA,
    output logic [31:0]      OPB_ADDR,
    output logic [31:0]      SP_DI,
    output logic             SP_RE,
    output logic             SP_WE,
    input  logic [31:0]      SP_DO,
    output logic             BUSY,
    output logic [CNT_W-1:0] RD_CNT,
    output logic [CNT_W-1:0] WR_CNT
);

    localparam int LW = 3;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     wait_q, wait_d;
    logic              wr_q, wr_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              sp_re_q, sp_re_d;
    logic              sp_we_q, sp_we_d;
    logic [31:0]       opb_addr_q, opb_addr_d;
    logic [31:0]       sp_di_q, sp_di_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              acc;
    logic              last_wait;

    assign acc       = (state_q == IDLE) & cmd_ready_q & CMD_VALID;
    assign last_wait = (state_q == WAIT) & (wait_q == LW'(1));

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            wr_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            sp_re_q     <= 1'b0;
            sp_we_q     <= 1'b0;
            opb_addr_q  <= '0;
            sp_di_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            wr_q        <= wr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            sp_re_q     <= sp_re_d;
            sp_we_q     <= sp_we_d;
            opb_addr_q  <= opb_addr_d;
            sp_di_q     <= sp_di_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (acc) state_d = STROBE;
            STROBE:  state_d = wr_q ? RESP : WAIT;
            WAIT:    if (last_wait) state_d = RESP;
            RESP:    if (rsp_valid_q & RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with it.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
        sp_re_d     = acc & ~CMD_WR;
        sp_we_d     = acc & CMD_WR;
        opb_addr_d  = opb_addr_q;
        sp_di_d     = sp_di_q;
        wr_d        = wr_q;
        wait_d      = wait_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (acc) begin
            opb_addr_d = CMD_ADDR;
            sp_di_d    = CMD_WR ? CMD_WDATA : 32'h0;
            wr_d       = CMD_WR;
        end
        unique case (state_q)
            STROBE: begin
                wait_d = LW'(RD_LATENCY);
                if (wr_q) begin
                    rsp_wr_d    = 1'b1;
                    rsp_rdata_d = 32'h0;
                    wr_cnt_d    = wr_cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                wait_d = wait_q - LW'(1);
                if (last_wait) begin
                    rsp_wr_d    = 1'b0;
                    rsp_rdata_d = SP_DO;
                    rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign CMD_READY = cmd_ready_q;
    assign BUSY      = busy_q;
    assign SP_RE     = sp_re_q;
    assign SP_WE     = sp_we_q;
    assign OPB_ADDR  = opb_addr_q;
    assign SP_DI     = sp_di_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_WR    = rsp_wr_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RD_CNT    = rd_cnt_q;
    assign WR_CNT    = wr_cnt_q;

endmodule

// File: tb/tb_opb_reg_master.sv
// Bench for opb_reg_master: random and directed commands, register-file
// slave model, queue scoreboard drained by an independent response monitor.
module tb_opb_reg_master;

    localparam int LAT = 3;
    localparam int CW  = 8;
    localparam logic [31:0] VERSION = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic          CMD_WR = 1'b0;
    logic [31:0]   CMD_ADDR = '0;
    logic [31:0]   CMD_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic          RSP_WR;
    logic [31:0]   RSP_RDATA;
    logic [31:0]   OPB_ADDR;
    logic [31:0]   SP_DI;
    logic          SP_RE;
    logic          SP_WE;
    logic [31:0]   SP_DO = '0;
    logic          BUSY;
    logic [CW-1:0] RD_CNT;
    logic [CW-1:0] WR_CNT;

    always #5 clk = ~clk;

    opb_reg_master #(.RD_LATENCY(LAT), .CNT_W(CW)) dut (
        .OPB_CLK(clk), .OPB_RST_N(rst_n),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WR(CMD_WR), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_WR(RSP_WR), .RSP_RDATA(RSP_RDATA),
        .OPB_ADDR(OPB_ADDR), .SP_DI(SP_DI), .SP_RE(SP_RE), .SP_WE(SP_WE),
        .SP_DO(SP_DO), .BUSY(BUSY), .RD_CNT(RD_CNT), .WR_CNT(WR_CNT)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    rsp_t        sbq[$];
    logic [31:0] mdl_mem [16];
    logic [31:0] slv_mem [16];
    int          exp_rd = 0;
    int          exp_wr = 0;
    int          slave_lat = LAT;
    int          rdy_mode = 1;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_di = '0;
    bit          burst = 0;
    int          cyc = 0;
    int          last_we = -1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Peripheral: register file, VERSION at 0, read data after slave_lat.
    int          cd = 0;
    logic [31:0] rd_data = '0;
    always @(negedge clk) begin
        SP_DO = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) SP_DO = rd_data;
        end
        if (SP_WE && OPB_ADDR[3:0] != 4'h0) slv_mem[OPB_ADDR[3:0]] = SP_DI;
        if (SP_RE) begin
            cd      = slave_lat;
            rd_data = slv_mem[OPB_ADDR[3:0]];
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       RSP_READY = ($urandom_range(0, 3) != 0);
            1:       RSP_READY = 1'b1;
            default: RSP_READY = 1'b0;
        endcase
    end

    // Strobe monitor.
    logic prev_stb = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stb = 1'b0;
        end else begin
            if (SP_RE || SP_WE) begin
                chk("single_strobe", {31'h0, SP_RE & SP_WE}, 32'h0);
                chk("no_consecutive_strobe", {31'h0, prev_stb}, 32'h0);
                chk("strobe_addr", OPB_ADDR, cur_addr);
                chk("strobe_di", SP_DI, cur_di);
            end
            if (SP_WE && burst) begin
                if (last_we >= 0) chk("we_spacing", cyc - last_we, 3);
                last_we = cyc;
            end
            prev_stb = SP_RE | SP_WE;
        end
    end

    // Response monitor.
    bit          held = 0;
    logic [31:0] held_data;
    logic        held_wr;
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            held = 0;
        end else if (RSP_VALID) begin
            chk("cmd_ready_in_resp", {31'h0, CMD_READY}, 32'h0);
            chk("busy_in_resp", {31'h0, BUSY}, 32'h1);
            if (held) begin
                chk("rsp_rdata_stable", RSP_RDATA, held_data);
                chk("rsp_wr_stable", {31'h0, RSP_WR}, {31'h0, held_wr});
            end
            if (RSP_READY) begin
                held = 0;
                if (sbq.size() == 0) begin
                    fail("unexpected_response");
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_wr", {31'h0, RSP_WR}, {31'h0, e.wr});
                    chk("rsp_rdata", RSP_RDATA, e.data);
                    if (e.wr) exp_wr++;
                    else exp_rd++;
                    chk("wr_cnt", {24'h0, WR_CNT}, 32'(exp_wr % (1 << CW)));
                    chk("rd_cnt", {24'h0, RD_CNT}, 32'(exp_rd % (1 << CW)));
                end
            end else begin
                held      = 1;
                held_data = RSP_RDATA;
                held_wr   = RSP_WR;
            end
        end
    end

    // Issue one command starting at a negedge; returns at the negedge of
    // the strobe cycle. Expected response is derived from the model memory.
    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
        bit ok = 0;
        CMD_VALID = 1'b1;
        CMD_WR    = wr;
        CMD_ADDR  = addr;
        CMD_WDATA = data;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (CMD_READY) begin
                ok = 1;
                if (wr) begin
                    if (addr[3:0] != 4'h0) mdl_mem[addr[3:0]] = data;
                    sbq.push_back('{wr: 1'b1, data: 32'h0});
                end else begin
                    sbq.push_back('{wr: 1'b0,
                        data: (slave_lat == LAT) ? mdl_mem[addr[3:0]] : 32'h0});
                end
                cur_addr = addr;
                cur_di   = wr ? data : 32'h0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        CMD_VALID = 1'b0;
        CMD_WR    = 1'($urandom);
        CMD_ADDR  = $urandom;
        CMD_WDATA = $urandom;
        if (!ok) fail("cmd_accept_timeout");
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (sbq.size() == 0 && !BUSY) ok = 1;
            else @(negedge clk);
        end
        if (!ok) fail("drain_timeout");
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_cmd_ready"}, {31'h0, CMD_READY}, 32'h0);
        chk({t, "_rsp_valid"}, {31'h0, RSP_VALID}, 32'h0);
        chk({t, "_rsp_wr"}, {31'h0, RSP_WR}, 32'h0);
        chk({t, "_strobes"}, {30'h0, SP_RE, SP_WE}, 32'h0);
        chk({t, "_busy"}, {31'h0, BUSY}, 32'h0);
        chk({t, "_rsp_rdata"}, RSP_RDATA, 32'h0);
        chk({t, "_opb_addr"}, OPB_ADDR, 32'h0);
        chk({t, "_sp_di"}, SP_DI, 32'h0);
        chk({t, "_cnts"}, {16'h0, RD_CNT, WR_CNT}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 16; i++) begin
            mdl_mem[i] = '0;
            slv_mem[i] = '0;
        end
        mdl_mem[0] = VERSION;
        slv_mem[0] = VERSION;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", {31'h0, CMD_READY}, 32'h1);
        @(negedge clk);

        // VERSION read with exact latency
        issue(1'b0, 32'h0, 32'h0);
        chk("sp_re_in_strobe", {31'h0, SP_RE}, 32'h1);
        n = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            n++;
            if (RSP_VALID) found = 1;
        end
        if (!found) fail("read_rsp_timeout");
        else chk("read_latency", n, LAT + 1);
        drain();

        issue(1'b1, 32'h3, 32'hA5A5_A5A5);
        issue(1'b0, 32'h3, 32'h0);
        drain();

        // Response stall for five cycles
        rdy_mode = 2;
        issue(1'b0, 32'h3, 32'h0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (RSP_VALID) found = 1;
        end
        if (!found) fail("stall_rsp_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {31'h0, RSP_VALID}, 32'h1);
            chk("stall_no_strobe", {30'h0, SP_RE, SP_WE}, 32'h0);
            if (i == 4) rdy_mode = 1;
            else @(negedge clk);
        end
        drain();

        // Peripheral answering too early is not captured
        slave_lat = 1;
        issue(1'b0, 32'h3, 32'h0);
        drain();
        slave_lat = LAT;

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rdy_mode = 1;

        // Reset in the middle of a read
        issue(1'b0, 32'h5, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("midop");
        sbq.delete();
        exp_rd = 0;
        exp_wr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {31'h0, RSP_VALID}, 32'h0);
        end
        chk("rd_cnt_after_reset", {24'h0, RD_CNT}, 32'h0);

        // Back-to-back writes across the counter wrap
        burst   = 1;
        last_we = -1;
        for (int i = 0; i < (1 << CW) + 1; i++)
            issue(1'b1, $urandom, $urandom);
        drain();
        burst = 0;
        chk("wr_cnt_wrapped", {24'h0, WR_CNT}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
